mux2_rr_arbiter: RTL

- Shares one WIDTH-bit output channel between two requesters, A and B. Each requester and the output use a valid/ready handshake.
- Round-robin arbitration with a configurable burst length drives the select of a 2:1 mux datapath (S=0 selects A, S=1 selects B).
- The muxed word is captured in a single output register.
- Sits in front of any shared sink (bus, FIFO, serializer) that consumes one word per accepted handshake.

---
 rtl/mux2_rr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: shares one registered WIDTH-bit output channel between two
// valid/ready requesters (A, B) using round-robin arbitration with a burst
// allowance. A source may keep the channel for up to BURST_LEN consecutive
// words while the other source is also requesting.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   a_valid/a_data/a_ready   requester A handshake
//   b_valid/b_data/b_ready   requester B handshake
//   out_valid/out_data/out_ready  registered output handshake
//   out_sel              source of out_data (0=A, 1=B)
//
// BURST_LEN must lie in 1..15 (the burst counter is 4 bits wide).

// One bit of the 2:1 datapath mux (sel=0 -> a, sel=1 -> b).
module mux2_rr_lane (
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = sel ? b : a;
endmodule

module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_sel
);

  localparam int CW = 4;
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  // state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_sel_q,   out_sel_d;
  src_e             last_grant_q, last_grant_d;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;

  // combinational
  logic             load_en;
  logic             grant_a, grant_b;
  logic             keep_last;
  src_e             gsrc;
  logic [WIDTH-1:0] mux_data;

  // 2:1 datapath, one lane per bit, select driven by the arbiter
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mux2_rr_lane u_lane (
      .sel (grant_b),
      .a   (a_data[i]),
      .b   (b_data[i]),
      .y   (mux_data[i])
    );
  end

  // Arbitration. A zero burst count only exists straight out of reset; it
  // means "no burst in progress", so a tie goes to the source opposite
  // last_grant (A, since last_grant resets to B).
  always_comb begin
    load_en   = !out_valid_q || out_ready;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    keep_last = (burst_cnt_q != '0) && (burst_cnt_q < BL);
    unique case ({a_valid, b_valid})
      2'b10:   grant_a = 1'b1;
      2'b01:   grant_b = 1'b1;
      2'b11: begin
        if (keep_last) begin
          grant_a = (last_grant_q == SRC_A);
          grant_b = (last_grant_q == SRC_B);
        end else begin
          grant_a = (last_grant_q == SRC_B);
          grant_b = (last_grant_q == SRC_A);
        end
      end
      default: ;
    endcase
    gsrc = grant_b ? SRC_B : SRC_A;
    // rst_n gate keeps both readies low for the whole reset window, when
    // the cleared out_valid would otherwise open load_en.
    a_ready = rst_n && load_en && grant_a;
    b_ready = rst_n && load_en && grant_b;
  end

  // Next state
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    if (load_en) begin
      if (grant_a || grant_b) begin
        out_valid_d = 1'b1;
        out_data_d  = mux_data;
        out_sel_d   = grant_b;
        if (gsrc == last_grant_q) begin
          // saturate so a late-arriving other source wins immediately
          burst_cnt_d = (burst_cnt_q >= BL) ? BL : burst_cnt_q + 1'b1;
        end else begin
          burst_cnt_d  = CW'(1);
          last_grant_d = gsrc;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= 1'b0;
      last_grant_q <= SRC_B;
      burst_cnt_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
